sprite_area_arbiter: RTL and testbench
======================================

SPRITE_AREA_ARBITER -- requirements
Module: sprite_area_arbiter

Interface
REQ-001 Parameter N_SPR, default 4: number of sprite channels (2..16).
REQ-002 Parameter COORD_W, default 10: pixel coordinate width.
REQ-003 Parameter SIZE_W, default 6: sprite width/height field width; max sprite extent 2^SIZE_W-1.
REQ-004 CLK  in  1  single clock; all state updates on rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 WR_EN  in  1  descriptor write strobe.
REQ-007 WR_IDX  in  clog2(N_SPR)  channel index written.
REQ-008 WR_POS_X / WR_POS_Y  in  COORD_W each  sprite top-left corner.
REQ-009 WR_W / WR_H  in  SIZE_W each  sprite width/height in pixels.
REQ-010 WR_ACT  in  1  channel active bit.
REQ-011 PIX_VALID  in  1  X/Y qualifier.
REQ-012 X / Y  in  COORD_W each  current pixel coordinate.
REQ-013 CLR_COLL  in  1  clears sticky collision flag.
REQ-014 HIT_VALID  out  1  output qualifier.
REQ-015 HIT  out  1  pixel inside at least one active sprite.
REQ-016 HIT_IDX  out  clog2(N_SPR)  lowest-index hit channel.
REQ-017 DIFF_X_COUNT / DIFF_Y_COUNT  out  SIZE_W each  pixel offset inside winning sprite.
REQ-018 COLL  out  1  two or more channels hit this pixel.
REQ-019 COLL_STICKY  out  1  latched collision since last clear.

Function
REQ-020 Descriptor table SHALL hold N_SPR entries {pos_x, pos_y, w, h, act}; write with WR_EN=1 takes effect at the next edge.
REQ-021 A pixel presented in the same cycle as a write to the same channel SHALL be evaluated against the old descriptor.
REQ-022 Channel i SHALL hit iff act=1 and pos_x <= X <= pos_x+w-1 and pos_y <= Y <= pos_y+h-1, all comparisons unsigned in COORD_W+1 bits (no wrap at 2^COORD_W).
REQ-023 w=0 or h=0 SHALL never hit.
REQ-024 Offsets SHALL be X-pos_x and Y-pos_y truncated to SIZE_W.
REQ-025 Pipeline stage 1 SHALL register per-channel hit bits and offsets; stage 2 SHALL register the priority-selected result; latency PIX_VALID -> HIT_VALID exactly 2 cycles, throughput 1 pixel/cycle.
REQ-026 Priority SHALL be fixed: lowest channel index wins.
REQ-027 When HIT=0: HIT_IDX=0, DIFF_X_COUNT=0, DIFF_Y_COUNT=0.
REQ-028 When PIX_VALID=0 in a cycle, the corresponding output cycle SHALL have HIT_VALID=0, HIT=0, COLL=0.
REQ-029 COLL SHALL be 1 when popcount of stage-1 hit bits >= 2, aligned with HIT_VALID.
REQ-030 COLL_STICKY SHALL set on any cycle with HIT_VALID=1 and COLL=1; CLR_COLL clears it at the next edge; simultaneous set and clear: set wins.

Reset
REQ-031 RST_N=0 SHALL immediately clear all descriptors (act=0, positions/sizes 0), both pipeline stages, and all outputs to 0.
REQ-032 Pixels in flight when reset asserts SHALL be discarded; first valid output after release appears 2 cycles after first PIX_VALID.

Structure
REQ-033 Shared package gpu_pkg SHALL hold COORD_W, SIZE_W defaults and sprite descriptor struct typedef.
REQ-034 One sub-module sprite_area_compare (single-channel hit + offset, combinational) SHALL be instantiated N_SPR times.
REQ-035 Target size 120-400 lines RTL total.

Verification
REQ-036 Sprite0 {100,50,32,32,act}, pixel (100,50) -> 2 cycles later HIT=1, HIT_IDX=0, DIFF=(0,0); pixel (131,81) -> DIFF=(31,31); (132,81) -> HIT=0.
REQ-037 Sprite0 {10,10,8,8}, sprite2 {12,12,8,8}, pixel (13,13) -> HIT_IDX=0, DIFF=(3,3), COLL=1, COLL_STICKY=1 until CLR_COLL.
REQ-038 Sprite1 {1020,0,10,4}, pixel (1023,0) -> HIT=1, DIFF_X=3; pixel (0,0) -> HIT=0 (no wrap).
REQ-039 Write sprite0 act=0 in same cycle as pixel inside it -> that pixel HIT=1, next pixel HIT=0.
REQ-040 Assert RST_N=0 mid-stream with two pixels in flight -> outputs 0 immediately, no HIT_VALID after release until 2 cycles after a new PIX_VALID.
REQ-041 Width 0 sprite at pixel's exact position -> HIT=0, COLL=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared sprite-engine definitions: default coordinate/size widths and the
// sprite descriptor layout.
package gpu_pkg;

    localparam int unsigned COORD_W_DEF = 10;
    localparam int unsigned SIZE_W_DEF  = 6;

    typedef struct packed {
        logic [COORD_W_DEF-1:0] pos_x;
        logic [COORD_W_DEF-1:0] pos_y;
        logic [SIZE_W_DEF-1:0]  w;
        logic [SIZE_W_DEF-1:0]  h;
        logic                   act;
    } sprite_desc_t;

endpackage

// File: rtl/sprite_area_compare.sv
// Single-channel sprite rectangle test: combinational hit flag plus pixel
// offset relative to the sprite's top-left corner.
module sprite_area_compare
    import gpu_pkg::*;
#(
    parameter int unsigned COORD_W = COORD_W_DEF,
    parameter int unsigned SIZE_W  = SIZE_W_DEF
) (
    input  logic [COORD_W-1:0] pos_x,
    input  logic [COORD_W-1:0] pos_y,
    input  logic [SIZE_W-1:0]  w,
    input  logic [SIZE_W-1:0]  h,
    input  logic               act,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output logic               hit,
    output logic [SIZE_W-1:0]  off_x,
    output logic [SIZE_W-1:0]  off_y
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             in_x;
    logic             in_y;

    // One extra bit keeps pos+size from wrapping back to the left/top edge.
    assign x_end = (COORD_W+1)'(pos_x) + (COORD_W+1)'(w);
    assign y_end = (COORD_W+1)'(pos_y) + (COORD_W+1)'(h);

    assign in_x = (x >= pos_x) && ((COORD_W+1)'(x) < x_end);
    assign in_y = (y >= pos_y) && ((COORD_W+1)'(y) < y_end);

    assign hit   = act && (w != '0) && (h != '0) && in_x && in_y;
    assign off_x = SIZE_W'(x - pos_x);
    assign off_y = SIZE_W'(y - pos_y);

endmodule

// File: rtl/sprite_area_arbiter.sv
// Sprite area arbiter: per-pixel hit test against N_SPR descriptors, fixed
// lowest-index priority, collision detection, two-stage pipeline.
module sprite_area_arbiter
    import gpu_pkg::*;
#(
    parameter  int unsigned N_SPR   = 4,
    parameter  int unsigned COORD_W = COORD_W_DEF,
    parameter  int unsigned SIZE_W  = SIZE_W_DEF,
    localparam int unsigned IDX_W   = $clog2(N_SPR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_pos_x,
    input  logic [COORD_W-1:0] wr_pos_y,
    input  logic [SIZE_W-1:0]  wr_w,
    input  logic [SIZE_W-1:0]  wr_h,
    input  logic               wr_act,
    input  logic               pix_valid,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               clr_coll,
    output logic               hit_valid,
    output logic               hit,
    output logic [IDX_W-1:0]   hit_idx,
    output logic [SIZE_W-1:0]  diff_x_count,
    output logic [SIZE_W-1:0]  diff_y_count,
    output logic               coll,
    output logic               coll_sticky
);

    typedef struct packed {
        logic [COORD_W-1:0] pos_x;
        logic [COORD_W-1:0] pos_y;
        logic [SIZE_W-1:0]  w;
        logic [SIZE_W-1:0]  h;
        logic               act;
    } desc_t;

    desc_t              desc_q [N_SPR];

    logic [N_SPR-1:0]   cmp_hit;
    logic [SIZE_W-1:0]  cmp_dx [N_SPR];
    logic [SIZE_W-1:0]  cmp_dy [N_SPR];

    logic               s1_valid_q;
    logic [N_SPR-1:0]   s1_hit_q;
    logic [SIZE_W-1:0]  s1_dx_q [N_SPR];
    logic [SIZE_W-1:0]  s1_dy_q [N_SPR];

    logic               sel_hit;
    logic [IDX_W-1:0]   sel_idx;
    logic [SIZE_W-1:0]  sel_dx;
    logic [SIZE_W-1:0]  sel_dy;
    logic               sel_coll;

    // Descriptor table; a write lands at the edge, so a same-cycle pixel sees the old entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SPR; i++) begin
                desc_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_SPR; i++) begin
                if (wr_en && (wr_idx == IDX_W'(i))) begin
                    desc_q[i] <= '{pos_x: wr_pos_x, pos_y: wr_pos_y,
                                   w: wr_w, h: wr_h, act: wr_act};
                end
            end
        end
    end

    for (genvar g = 0; g < N_SPR; g++) begin : g_cmp
        sprite_area_compare #(
            .COORD_W (COORD_W),
            .SIZE_W  (SIZE_W)
        ) u_cmp (
            .pos_x (desc_q[g].pos_x),
            .pos_y (desc_q[g].pos_y),
            .w     (desc_q[g].w),
            .h     (desc_q[g].h),
            .act   (desc_q[g].act),
            .x     (x),
            .y     (y),
            .hit   (cmp_hit[g]),
            .off_x (cmp_dx[g]),
            .off_y (cmp_dy[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= '0;
            for (int i = 0; i < N_SPR; i++) begin
                s1_dx_q[i] <= '0;
                s1_dy_q[i] <= '0;
            end
        end else begin
            s1_valid_q <= pix_valid;
            s1_hit_q   <= pix_valid ? cmp_hit : '0;
            for (int i = 0; i < N_SPR; i++) begin
                s1_dx_q[i] <= cmp_dx[i];
                s1_dy_q[i] <= cmp_dy[i];
            end
        end
    end

    // First hit found wins; any later hit marks a collision.
    always_comb begin
        sel_hit  = 1'b0;
        sel_idx  = '0;
        sel_dx   = '0;
        sel_dy   = '0;
        sel_coll = 1'b0;
        for (int i = 0; i < N_SPR; i++) begin
            if (s1_hit_q[i]) begin
                if (sel_hit) begin
                    sel_coll = 1'b1;
                end else begin
                    sel_hit = 1'b1;
                    sel_idx = IDX_W'(i);
                    sel_dx  = s1_dx_q[i];
                    sel_dy  = s1_dy_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_valid    <= 1'b0;
            hit          <= 1'b0;
            hit_idx      <= '0;
            diff_x_count <= '0;
            diff_y_count <= '0;
            coll         <= 1'b0;
            coll_sticky  <= 1'b0;
        end else begin
            hit_valid    <= s1_valid_q;
            hit          <= sel_hit;
            hit_idx      <= sel_idx;
            diff_x_count <= sel_dx;
            diff_y_count <= sel_dy;
            coll         <= sel_coll;
            coll_sticky  <= (s1_valid_q && sel_coll) || (coll_sticky && !clr_coll);
        end
    end

endmodule

// File: tb/tb_sprite_area_arbiter.sv
// Directed bench for sprite_area_arbiter with hand-computed expectations.
module tb_sprite_area_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [9:0] wr_pos_x, wr_pos_y;
    logic [5:0] wr_w, wr_h;
    logic       wr_act;
    logic       pix_valid;
    logic [9:0] x, y;
    logic       clr_coll;
    logic       hit_valid, hit, coll, coll_sticky;
    logic [1:0] hit_idx;
    logic [5:0] diff_x_count, diff_y_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sprite_area_arbiter dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_idx       (wr_idx),
        .wr_pos_x     (wr_pos_x),
        .wr_pos_y     (wr_pos_y),
        .wr_w         (wr_w),
        .wr_h         (wr_h),
        .wr_act       (wr_act),
        .pix_valid    (pix_valid),
        .x            (x),
        .y            (y),
        .clr_coll     (clr_coll),
        .hit_valid    (hit_valid),
        .hit          (hit),
        .hit_idx      (hit_idx),
        .diff_x_count (diff_x_count),
        .diff_y_count (diff_y_count),
        .coll         (coll),
        .coll_sticky  (coll_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic ehv, input logic ehit,
                         input logic [1:0] eidx, input logic [5:0] edx,
                         input logic [5:0] edy, input logic ecoll, input logic est);
        logic [17:0] obs;
        logic [17:0] exp;
        obs = {hit_valid, hit, hit_idx, diff_x_count, diff_y_count, coll, coll_sticky};
        exp = {ehv, ehit, eidx, edx, edy, ecoll, est};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_desc(input logic [1:0] idx, input logic [9:0] px, input logic [9:0] py,
                            input logic [5:0] w, input logic [5:0] h, input logic act);
        wr_en    = 1'b1;
        wr_idx   = idx;
        wr_pos_x = px;
        wr_pos_y = py;
        wr_w     = w;
        wr_h     = h;
        wr_act   = act;
    endtask

    task automatic write_desc(input logic [1:0] idx, input logic [9:0] px, input logic [9:0] py,
                              input logic [5:0] w, input logic [5:0] h, input logic act);
        set_desc(idx, px, py, w, h, act);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic present(input logic [9:0] px, input logic [9:0] py);
        pix_valid = 1'b1;
        x         = px;
        y         = py;
    endtask

    initial begin
        rst_n = 1'b1;
        wr_en = 1'b0; wr_idx = '0; wr_pos_x = '0; wr_pos_y = '0;
        wr_w = '0; wr_h = '0; wr_act = 1'b0;
        pix_valid = 1'b0; x = '0; y = '0; clr_coll = 1'b0;
        #1 rst_n = 1'b0;
        #20;
        check("reset", 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        // Single sprite, corners and one past the right edge.
        write_desc(0, 100, 50, 32, 32, 1);
        present(100, 50); tick();
        pix_valid = 1'b0; tick();
        check("corner_tl", 1, 1, 0, 0, 0, 0, 0);
        present(131, 81); tick();
        present(132, 81); tick();
        check("corner_br", 1, 1, 0, 31, 31, 0, 0);
        pix_valid = 1'b0; tick();
        check("past_right", 1, 0, 0, 0, 0, 0, 0);
        tick();
        check("idle", 0, 0, 0, 0, 0, 0, 0);

        // Overlap, collision, sticky flag behaviour.
        write_desc(0, 10, 10, 8, 8, 1);
        write_desc(2, 12, 12, 8, 8, 1);
        present(13, 13); tick();
        pix_valid = 1'b0; tick();
        check("overlap", 1, 1, 0, 3, 3, 1, 1);
        tick();
        check("sticky_hold", 0, 0, 0, 0, 0, 0, 1);
        clr_coll = 1'b1; tick(); clr_coll = 1'b0;
        check("sticky_clr", 0, 0, 0, 0, 0, 0, 0);
        present(13, 13); tick();
        pix_valid = 1'b0; clr_coll = 1'b1; tick(); clr_coll = 1'b0;
        check("set_wins", 1, 1, 0, 3, 3, 1, 1);
        clr_coll = 1'b1; tick(); clr_coll = 1'b0;
        check("sticky_clr2", 0, 0, 0, 0, 0, 0, 0);
        present(18, 18); tick();
        pix_valid = 1'b0; tick();
        check("idx2_only", 1, 1, 2, 6, 6, 0, 0);

        // Right screen edge, no wrap back to column 0.
        write_desc(1, 1020, 0, 10, 4, 1);
        present(1023, 0); tick();
        present(0, 0); tick();
        check("edge_1023", 1, 1, 1, 3, 0, 0, 0);
        pix_valid = 1'b0; tick();
        check("no_wrap", 1, 0, 0, 0, 0, 0, 0);

        // Same-cycle write uses old descriptor.
        set_desc(0, 10, 10, 8, 8, 0);
        present(11, 11); tick();
        wr_en = 1'b0; tick();
        pix_valid = 1'b0;
        check("wr_old_desc", 1, 1, 0, 1, 1, 0, 0);
        tick();
        check("wr_new_desc", 1, 0, 0, 0, 0, 0, 0);

        // Zero-size sprites never hit.
        write_desc(3, 0, 0, 0, 4, 1);
        present(0, 0); tick();
        pix_valid = 1'b0; tick();
        check("zero_w", 1, 0, 0, 0, 0, 0, 0);
        write_desc(3, 200, 200, 4, 0, 1);
        present(200, 200); tick();
        pix_valid = 1'b0; tick();
        check("zero_h", 1, 0, 0, 0, 0, 0, 0);
        write_desc(3, 200, 200, 4, 4, 1);
        present(203, 203); tick();
        pix_valid = 1'b0; tick();
        check("idx3", 1, 1, 3, 3, 3, 0, 0);

        // Reset with pixels in flight.
        present(13, 13); tick();
        present(14, 14); tick();
        check("pre_rst", 1, 1, 2, 1, 1, 0, 0);
        rst_n = 1'b0; pix_valid = 1'b0;
        #1;
        check("rst_async", 0, 0, 0, 0, 0, 0, 0);
        tick();
        #3 rst_n = 1'b1;
        tick(); tick();
        check("no_ghost", 0, 0, 0, 0, 0, 0, 0);
        present(13, 13); tick();
        pix_valid = 1'b0;
        check("lat_1cyc", 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("desc_cleared", 1, 0, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
